// File: rtl/ahb_sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_pkg
//  Purpose  : Shared encodings, default sizes and address helper for the
//             AHB-Lite SRAM slave.
//  Revision : 1.0  initial release
// ============================================================================
package ahb_sram_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 31;
    localparam int DEPTH_DEF  = 256;

    localparam logic HTRANS_IDLE   = 1'b0;
    localparam logic HTRANS_ACTIVE = 1'b1;
    localparam logic HBURST_SINGLE = 1'b0;
    localparam logic HBURST_INCR   = 1'b1;

    // Source of the registered read-data output during a data phase.
    typedef enum logic [1:0] {
        RD_SRC_ZERO = 2'd0,
        RD_SRC_RAM  = 2'd1,
        RD_SRC_FWD  = 2'd2
    } rd_src_e;

    // Byte address to word number; callers slice the low bits for the index.
    function automatic logic [ADDR_W_DEF-3:0] word_of(input logic [ADDR_W_DEF-1:0] haddr);
        return haddr[ADDR_W_DEF-1:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_array.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_array
//  Purpose  : Word-organised synchronous RAM, one write port and one
//             registered read port, no reset on the storage.
//  Revision : 1.0  initial release
// ============================================================================
module ahb_sram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read returns the pre-write contents; same-cycle collisions are
    // resolved by the forwarding path in the parent.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_slave
//  Purpose  : Zero-wait-state AHB-Lite slave in front of an on-chip RAM;
//             address-phase capture, write-first forwarding, HREADY.
//  Revision : 1.0  initial release
// ============================================================================
module ahb_sram_slave
    import ahb_sram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL1,
    input  logic              HTRANS,
    input  logic              HBURST,
    input  logic              HWRITE,
    input  logic              HREADY_Prev,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [DATA_W-1:0] HWDATA,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADY
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [ADDR_W_DEF-3:0] w_word;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_accept;
    logic                  w_rd;
    logic                  w_we;
    logic                  w_hazard;
    logic [DATA_W-1:0]     w_ram_rdata;
    logic                  w_unused_bits;

    logic                  r_pend_wr;
    logic [IDX_W-1:0]      r_pend_addr;
    rd_src_e               r_rd_src;
    logic [DATA_W-1:0]     r_fwd_data;

    assign w_word   = word_of(ADDR_W_DEF'(HADDR));
    assign w_idx    = w_word[IDX_W-1:0];
    assign w_accept = HSEL1 & (HTRANS == HTRANS_ACTIVE) & HREADY_Prev & ~HRESETn;
    assign w_rd     = w_accept & ~HWRITE;
    // A write data phase that lands on a reset cycle is discarded.
    assign w_we     = r_pend_wr & ~HRESETn;
    assign w_hazard = w_rd & r_pend_wr & (r_pend_addr == w_idx);

    // Burst type is informational; upper address bits alias onto the array.
    assign w_unused_bits = ^{HBURST, HADDR[1:0], w_word[ADDR_W_DEF-3:IDX_W]};

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            r_pend_wr   <= 1'b0;
            r_pend_addr <= '0;
            r_rd_src    <= RD_SRC_ZERO;
            r_fwd_data  <= '0;
        end else begin
            r_pend_wr <= w_accept & HWRITE;
            if (w_accept) begin
                r_pend_addr <= w_idx;
            end
            if (w_rd) begin
                r_rd_src <= w_hazard ? RD_SRC_FWD : RD_SRC_RAM;
                if (w_hazard) begin
                    r_fwd_data <= HWDATA;
                end
            end
        end
    end

    ahb_sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .i_clk   (HCLK),
        .i_we    (w_we),
        .i_waddr (r_pend_addr),
        .i_wdata (HWDATA),
        .i_re    (w_rd),
        .i_raddr (w_idx),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        HRDATA = '0;
        case (r_rd_src)
            RD_SRC_RAM: HRDATA = w_ram_rdata;
            RD_SRC_FWD: HRDATA = r_fwd_data;
            default:    HRDATA = '0;
        endcase
    end

    assign HREADY = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_sram_slave
//  Purpose  : Self-checking bench for ahb_sram_slave: directed vector table,
//             hand sequences and randomized traffic against a memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_sram_slave;

    localparam int DW    = 32;
    localparam int AW    = 31;
    localparam int DEPTH = 256;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b1;
    logic          HSEL1 = 1'b0;
    logic          HTRANS = 1'b0;
    logic          HBURST = 1'b0;
    logic          HWRITE = 1'b0;
    logic          HREADY_Prev = 1'b1;
    logic [AW-1:0] HADDR = '0;
    logic [DW-1:0] HWDATA = '0;
    logic [DW-1:0] HRDATA;
    logic          HREADY;

    int n_checks = 0;
    int n_errors = 0;

    ahb_sram_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSEL1       (HSEL1),
        .HTRANS      (HTRANS),
        .HBURST      (HBURST),
        .HWRITE      (HWRITE),
        .HREADY_Prev (HREADY_Prev),
        .HADDR       (HADDR),
        .HWDATA      (HWDATA),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY)
    );

    always #5 HCLK = ~HCLK;

    // Memory model: write data lands before a same-edge read looks at it.
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    bit            m_pend  = 1'b0;
    int            m_pidx  = 0;
    logic [DW-1:0] m_rd    = '0;
    bit            m_rd_ok = 1'b0;

    task automatic model_step(input bit rst, input bit sel, input bit trans, input bit rdy,
                              input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int  idx;
        bit  acc;
        idx = int'((addr / 4) % DEPTH);
        acc = sel && trans && rdy && !rst;
        if (!rst && m_pend) begin
            m_mem[m_pidx]   = wdata;
            m_known[m_pidx] = 1'b1;
        end
        if (rst) begin
            m_rd    = '0;
            m_rd_ok = 1'b1;
        end else if (acc && !wr) begin
            m_rd    = m_mem[idx];
            m_rd_ok = m_known[idx];
        end
        m_pend = acc && wr;
        m_pidx = idx;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, clock, update model, sample 1 ns after the edge.
    task automatic step(input bit rst, input bit sel, input bit trans, input bit rdy,
                        input bit wr, input bit burst, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata);
        HRESETn     = rst;
        HSEL1       = sel;
        HTRANS      = trans;
        HREADY_Prev = rdy;
        HWRITE      = wr;
        HBURST      = burst;
        HADDR       = addr;
        HWDATA      = wdata;
        @(posedge HCLK);
        model_step(rst, sel, trans, rdy, wr, addr, wdata);
        #1;
    endtask

    typedef struct {
        bit            rst, sel, trans, rdy, wr, burst;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            chk;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(bit rst, bit sel, bit trans, bit rdy, bit wr, bit burst,
                               logic [AW-1:0] a, logic [DW-1:0] d, bit chk, logic [DW-1:0] e);
        vec_t v;
        v.rst = rst; v.sel = sel; v.trans = trans; v.rdy = rdy; v.wr = wr; v.burst = burst;
        v.addr = a; v.wdata = d; v.chk = chk; v.exp = e;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b0;
        end

        //           rst sel tr rdy wr bu addr        wdata          chk exp
        tbl.push_back(V(1, 0, 0, 1, 0, 0, 31'h000,  32'h0,         1, 32'h0));
        tbl.push_back(V(0, 1, 0, 1, 0, 0, 31'h000,  32'h0,         1, 32'h0));
        tbl.push_back(V(0, 1, 1, 1, 1, 0, 31'h000,  32'h0,         0, 32'h0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 31'h000,  32'h12153524,  0, 32'h0));
        tbl.push_back(V(0, 1, 1, 1, 0, 0, 31'h000,  32'h0,         1, 32'h12153524));
        tbl.push_back(V(0, 1, 1, 1, 1, 0, 31'h000,  32'h0,         0, 32'h0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 31'h000,  32'hC0895E81,  0, 32'h0));
        tbl.push_back(V(1, 0, 0, 1, 0, 0, 31'h000,  32'h0,         1, 32'h0));
        tbl.push_back(V(0, 1, 1, 1, 0, 0, 31'h000,  32'h0,         1, 32'hC0895E81));
        tbl.push_back(V(0, 0, 1, 1, 1, 0, 31'h000,  32'hFFFFFFFF,  1, 32'hC0895E81));
        tbl.push_back(V(0, 1, 0, 1, 1, 0, 31'h000,  32'hFFFFFFFF,  1, 32'hC0895E81));
        tbl.push_back(V(0, 1, 1, 0, 1, 0, 31'h000,  32'hFFFFFFFF,  1, 32'hC0895E81));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 31'h000,  32'hFFFFFFFF,  1, 32'hC0895E81));
        tbl.push_back(V(0, 1, 1, 1, 0, 0, 31'h000,  32'h0,         1, 32'hC0895E81));
        tbl.push_back(V(0, 1, 1, 1, 1, 1, 31'h000,  32'h0,         0, 32'h0));
        tbl.push_back(V(0, 1, 1, 1, 1, 1, 31'h004,  32'hA,         0, 32'h0));
        tbl.push_back(V(0, 1, 1, 1, 1, 1, 31'h008,  32'hB,         0, 32'h0));
        tbl.push_back(V(0, 1, 1, 1, 1, 1, 31'h00C,  32'hC,         0, 32'h0));
        tbl.push_back(V(0, 1, 1, 1, 0, 1, 31'h000,  32'hD,         1, 32'hA));
        tbl.push_back(V(0, 1, 1, 1, 0, 1, 31'h004,  32'h0,         1, 32'hB));
        tbl.push_back(V(0, 1, 1, 1, 0, 1, 31'h008,  32'h0,         1, 32'hC));
        tbl.push_back(V(0, 1, 1, 1, 0, 1, 31'h00C,  32'h0,         1, 32'hD));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 31'h000,  32'h0,         1, 32'hD));
        tbl.push_back(V(0, 1, 1, 1, 1, 0, 31'h010,  32'h0,         0, 32'h0));
        tbl.push_back(V(0, 1, 1, 1, 0, 0, 31'h010,  32'h5A5A5A5A,  1, 32'h5A5A5A5A));
        tbl.push_back(V(0, 1, 1, 1, 0, 0, 31'h410,  32'h0,         1, 32'h5A5A5A5A));
        tbl.push_back(V(0, 1, 1, 1, 0, 0, 31'h013,  32'h0,         1, 32'h5A5A5A5A));
        tbl.push_back(V(0, 1, 1, 1, 1, 0, 31'h020,  32'h0,         0, 32'h0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 31'h000,  32'h11111111,  0, 32'h0));
        tbl.push_back(V(0, 1, 1, 1, 1, 0, 31'h020,  32'h0,         0, 32'h0));
        tbl.push_back(V(1, 0, 0, 1, 0, 0, 31'h000,  32'h22222222,  1, 32'h0));
        tbl.push_back(V(0, 1, 1, 1, 0, 0, 31'h020,  32'h0,         1, 32'h11111111));

        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].sel, tbl[k].trans, tbl[k].rdy, tbl[k].wr, tbl[k].burst,
                 tbl[k].addr, tbl[k].wdata);
            if (tbl[k].chk) check($sformatf("tbl[%0d] hrdata", k), HRDATA, tbl[k].exp);
            check($sformatf("tbl[%0d] hready", k), {31'h0, HREADY}, 32'h1);
        end

        // Back-to-back writes to one word, then a read forwarding the newest data.
        step(0, 1, 1, 1, 1, 1, 31'h040, 32'h0);
        step(0, 1, 1, 1, 1, 1, 31'h040, 32'h00000001);
        step(0, 1, 1, 1, 0, 0, 31'h040, 32'h00000002);
        check("ww_read fwd", HRDATA, 32'h00000002);
        step(0, 0, 0, 1, 0, 0, 31'h000, 32'h0);
        step(0, 1, 1, 1, 0, 0, 31'h040, 32'h0);
        check("ww_read ram", HRDATA, 32'h00000002);
        // A read address phase stalled by HREADY_Prev=0 must not update HRDATA.
        step(0, 1, 1, 0, 0, 0, 31'h000, 32'h0);
        check("stalled read hold", HRDATA, 32'h00000002);

        // Randomized traffic over a few words with aliased addresses.
        for (int n = 0; n < 600; n++) begin
            bit            r_rst, r_sel, r_tr, r_rdy, r_wr;
            logic [AW-1:0] a;
            r_rst = ($urandom_range(0, 39) == 0);
            r_sel = ($urandom_range(0, 9) != 0);
            r_tr  = ($urandom_range(0, 9) < 8);
            r_rdy = ($urandom_range(0, 19) < 17);
            r_wr  = $urandom_range(0, 1) == 1;
            a = AW'(($urandom_range(0, 7) * 4) + ($urandom & 3));
            if ($urandom_range(0, 1) == 1) a = a + AW'(DEPTH * 4 * $urandom_range(1, 5));
            step(r_rst, r_sel, r_tr, r_rdy, r_wr, $urandom_range(0, 1) == 1, a, $urandom);
            if (m_rd_ok) check($sformatf("rand[%0d] hrdata", n), HRDATA, m_rd);
            check($sformatf("rand[%0d] hready", n), {31'h0, HREADY}, 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
